// File: rtl/alsu_result_fifo.sv
// alsu_result_fifo: filters ALSU results by leds, buffers valid ones in a show-ahead FIFO with drop/overflow stats.
// Optional saturating accumulator of pushed results enabled by defining ALSU_RESULT_ACC_EN.
module alsu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               in_out,
  input  logic [15:0]              in_leds,
  output logic                     in_ready,
  output logic                     m_valid,
  output logic [5:0]               m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt,
  output logic                     overflow,
  output logic [ACC_W-1:0]         acc,
  input  logic                     clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop, lost;
  assign full     = count_q == CW'(DEPTH);
  assign empty    = count_q == '0;
  assign in_ready = !full;
  assign m_valid  = !empty;
  assign m_data   = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;
  assign drop     = in_valid && in_leds != '0;
  assign push     = in_valid && in_leds == '0 && !full;
  assign lost     = in_valid && in_leds == '0 && full;
  assign pop      = m_valid && m_ready;
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    drop_cnt_d = clr ? '0 : (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    overflow_d = clr ? 1'b0 : overflow_q | lost;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  // Storage needs no reset; m_data is don't-care while empty.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_out;
`ifdef ALSU_RESULT_ACC_EN
  logic [ACC_W-1:0] acc_q, acc_d, acc_sat;
  logic [ACC_W:0]   acc_sum;
  always_comb begin
    acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-5){in_out[5]}}, in_out};
    acc_sat = (acc_sum[ACC_W] != acc_sum[ACC_W-1]) ? {acc_sum[ACC_W], {(ACC_W-1){~acc_sum[ACC_W]}}} : acc_sum[ACC_W-1:0];
    acc_d   = clr ? '0 : push ? acc_sat : acc_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
`else
  assign acc = '0;
`endif
endmodule

// File: tb/tb_alsu_result_fifo.sv
// tb_alsu_result_fifo: randomized scoreboard bench for alsu_result_fifo against a queue-based reference model.
module tb_alsu_result_fifo;
  localparam int DEPTH = 8;
  localparam int ACC_W = 8;
  logic clk = 0, rst = 0;
  logic in_valid = 0, m_ready = 0, clr = 0;
  logic [5:0] in_out = 0;
  logic [15:0] in_leds = 0;
  logic in_ready, m_valid, full, empty, overflow;
  logic [5:0] m_data;
  logic [$clog2(DEPTH):0] count;
  logic [7:0] drop_cnt;
  logic [ACC_W-1:0] acc;
  int checks = 0, errors = 0;
  int exp_q[$];
  int occ = 0, drop_m = 0, acc_m = 0;
  bit ovf_m = 0;

  alsu_result_fifo #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_out(in_out), .in_leds(in_leds),
    .in_ready(in_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt),
    .overflow(overflow), .acc(acc), .clr(clr));

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_exp();
`ifdef ALSU_RESULT_ACC_EN
    return acc_m;
`else
    return 0;
`endif
  endfunction

  // Reference model: plain occupancy count, FIFO order kept by exp_q.
  always @(posedge clk or negedge rst) begin : model
    bit fullm, popm;
    if (!rst) begin
      exp_q.delete();
      occ = 0; drop_m = 0; acc_m = 0; ovf_m = 0;
    end else begin
      fullm = occ == DEPTH;
      popm  = occ > 0 && m_ready;
      if (in_valid) begin
        if (in_leds != 0) begin
          if (drop_m < 255) drop_m++;
        end else if (!fullm) begin
          exp_q.push_back(int'($signed(in_out)));
          occ++;
          acc_m += int'($signed(in_out));
          if (acc_m > 2**(ACC_W-1)-1) acc_m = 2**(ACC_W-1)-1;
          if (acc_m < -(2**(ACC_W-1))) acc_m = -(2**(ACC_W-1));
        end else ovf_m = 1;
      end
      if (popm) occ--;
      if (clr) begin drop_m = 0; ovf_m = 0; acc_m = 0; end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands over an entry.
  always @(negedge clk) if (rst) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("pop_on_empty_model", 1, 0);
      else chk("m_data", int'($signed(m_data)), exp_q.pop_front());
    end
    chk("count", int'(count), occ);
    chk("full", int'(full), int'(occ == DEPTH));
    chk("empty", int'(empty), int'(occ == 0));
    chk("m_valid", int'(m_valid), int'(occ != 0));
    chk("in_ready", int'(in_ready), int'(occ != DEPTH));
    chk("drop_cnt", int'(drop_cnt), drop_m);
    chk("overflow", int'(overflow), int'(ovf_m));
    chk("acc", int'($signed(acc)), acc_exp());
  end

  task automatic cyc(input bit v, input int d, input logic [15:0] l, input bit r, input bit c);
    in_valid = v; in_out = 6'(d); in_leds = l; m_ready = r; clr = c;
    @(posedge clk); #1;
    in_valid = 0; clr = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_empty", int'(empty), 1);
    // Test 1: reset with three entries buffered
    cyc(1, 1, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(1, 3, 0, 0, 0);
    chk("t1_count_pre", int'(count), 3);
    #2 rst = 0; #1;
    chk("t1_count", int'(count), 0);
    chk("t1_empty", int'(empty), 1);
    chk("t1_m_valid", int'(m_valid), 0);
    chk("t1_drop", int'(drop_cnt), 0);
    chk("t1_ovf", int'(overflow), 0);
    chk("t1_acc", int'($signed(acc)), 0);
    @(posedge clk); #1 rst = 1;
    chk("t1_in_ready", int'(in_ready), 1);
    // Test 2: ordered drain
    cyc(1, 5, 0, 0, 0); cyc(1, -3, 0, 0, 0); cyc(1, 31, 0, 0, 0);
    chk("t2_count", int'(count), 3);
    chk("t2_head", int'($signed(m_data)), 5);
    repeat (3) cyc(0, 0, 0, 1, 0);
    chk("t2_empty", int'(empty), 1);
    // Test 3: fill then overflow
    for (int i = 0; i < DEPTH; i++) cyc(1, i + 10, 0, 0, 0);
    chk("t3_full", int'(full), 1);
    chk("t3_in_ready", int'(in_ready), 0);
    cyc(1, 25, 0, 1, 0);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_count", int'(count), DEPTH - 1);
    repeat (DEPTH + 1) cyc(0, 0, 0, 1, 0);
    chk("t3_drained", int'(count), 0);
    // Test 4: drop saturation then clear
    for (int i = 0; i < 260; i++) cyc(1, 7, 16'hFFFF, 0, 0);
    chk("t4_drop_sat", int'(drop_cnt), 255);
    chk("t4_empty", int'(empty), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_drop_clr", int'(drop_cnt), 0);
    chk("t4_ovf_clr", int'(overflow), 0);
    // Test 5: steady push+pop at count 4
    for (int i = 0; i < 4; i++) cyc(1, i, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 20 - i, 0, 1, 0);
      chk("t5_count", int'(count), 4);
    end
    repeat (6) cyc(0, 0, 0, 1, 0);
    // Test 6: accumulator saturation
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 31, 0, 1, 0);
`ifdef ALSU_RESULT_ACC_EN
    chk("t6_acc_sat", int'($signed(acc)), 127);
`else
    chk("t6_acc_tied", int'($signed(acc)), 0);
`endif
    cyc(1, -32, 0, 1, 0);
`ifdef ALSU_RESULT_ACC_EN
    chk("t6_acc_neg", int'($signed(acc)), 95);
`endif
    cyc(0, 0, 0, 1, 1);
    chk("t6_acc_clr", int'($signed(acc)), 0);
    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
          ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
    repeat (DEPTH + 2) cyc(0, 0, 0, 1, 0);
    chk("final_empty", int'(empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
